// File: rtl/piano_play_ctrl.sv
// rtl/piano_play_ctrl.sv - playback sequencer: score generation, random/saved playback, looping, pause, abort
// Optional pause support is enabled by defining PIANO_PLAY_PAUSE_EN.
module piano_play_ctrl #(
  parameter int NUM_SLOTS = 4,
  parameter int SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
  parameter int LOOP_W    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s,
  input  logic                 done_gen_score,
  output logic                 do_new_score,
  output logic                 enable_rand,
  input  logic                 play_rand,
  input  logic                 play_save,
  input  logic [SLOT_W-1:0]    save_slot,
  input  logic [NUM_SLOTS-1:0] slot_valid,
  input  logic [LOOP_W-1:0]    loop_count,
  input  logic                 done_audio,
  input  logic                 end_early,
  input  logic                 pause_req,
  input  logic                 resume_req,
  input  logic                 change_score,
  input  logic                 replay,
  output logic                 init_audio,
  output logic                 play_en,
  output logic                 play_src,
  output logic [SLOT_W-1:0]    play_slot,
  output logic [LOOP_W-1:0]    loops_left,
  output logic                 paused,
  output logic                 done,
  output logic                 sel_err
);

`ifdef PIANO_PLAY_PAUSE_EN
  localparam logic PAUSE_EN = 1'b1;
`else
  localparam logic PAUSE_EN = 1'b0;
`endif

  localparam int PAD_W = 1 << SLOT_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GEN,
    S_READY,
    S_PLAY,
    S_PAUSE,
    S_DONE
  } state_t;

  state_t              state, next_state;
  logic                src_q, next_src;
  logic [SLOT_W-1:0]   slot_q, next_slot;
  logic [LOOP_W-1:0]   loops_q, next_loops;
  logic                init_q, next_init;
  logic                err_q, next_err;
  logic [PAD_W-1:0]    valid_pad;
  logic                slot_ok;

  // Padding the mask to the full index range folds the bounds check into the lookup.
  always_comb begin
    valid_pad                = '0;
    valid_pad[NUM_SLOTS-1:0] = slot_valid;
    slot_ok                  = valid_pad[save_slot];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      src_q   <= 1'b0;
      slot_q  <= '0;
      loops_q <= '0;
      init_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= next_state;
      src_q   <= next_src;
      slot_q  <= next_slot;
      loops_q <= next_loops;
      init_q  <= next_init;
      err_q   <= next_err;
    end
  end

  always_comb begin
    next_state = state;
    next_src   = src_q;
    next_slot  = slot_q;
    next_loops = loops_q;
    next_init  = 1'b0;
    next_err   = 1'b0;
    case (state)
      S_IDLE: begin
        if (s) next_state = S_GEN;
      end
      S_GEN: begin
        if (done_gen_score) next_state = S_READY;
      end
      S_READY: begin
        if (play_rand) begin
          next_state = S_PLAY;
          next_src   = 1'b0;
          next_loops = loop_count;
          next_init  = 1'b1;
        end else if (play_save) begin
          if (slot_ok) begin
            next_state = S_PLAY;
            next_src   = 1'b1;
            next_slot  = save_slot;
            next_loops = loop_count;
            next_init  = 1'b1;
          end else begin
            next_err = 1'b1;
          end
        end
      end
      S_PLAY: begin
        if (end_early) begin
          next_state = S_DONE;
          next_loops = '0;
        end else if (done_audio) begin
          if (loops_q != '0) begin
            next_loops = loops_q - LOOP_W'(1);
            next_init  = 1'b1;
          end else begin
            next_state = S_DONE;
          end
        end else if (PAUSE_EN && pause_req) begin
          next_state = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (end_early) begin
          next_state = S_DONE;
          next_loops = '0;
        end else if (resume_req) begin
          next_state = S_PLAY;
        end
      end
      S_DONE: begin
        if (change_score) begin
          next_state = S_GEN;
        end else if (replay) begin
          next_state = S_PLAY;
          next_loops = loop_count;
          next_init  = 1'b1;
        end else if (play_rand) begin
          next_state = S_PLAY;
          next_src   = 1'b0;
          next_loops = loop_count;
          next_init  = 1'b1;
        end else if (play_save) begin
          if (slot_ok) begin
            next_state = S_PLAY;
            next_src   = 1'b1;
            next_slot  = save_slot;
            next_loops = loop_count;
            next_init  = 1'b1;
          end else begin
            next_err = 1'b1;
          end
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  assign do_new_score = (state == S_GEN);
  assign enable_rand  = (state == S_GEN);
  assign play_en      = (state == S_PLAY);
  assign paused       = PAUSE_EN && (state == S_PAUSE);
  assign done         = (state == S_DONE);
  assign init_audio   = init_q;
  assign sel_err      = err_q;
  assign play_src     = src_q;
  assign play_slot    = slot_q;
  assign loops_left   = loops_q;

endmodule

// File: tb/tb_piano_play_ctrl.sv
// tb/tb_piano_play_ctrl.sv - directed and randomized checks of piano_play_ctrl against a behavioural model
module tb_piano_play_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s = 0, done_gen_score = 0, play_rand = 0, play_save = 0;
  logic [1:0] save_slot = 0;
  logic [3:0] slot_valid = 0, loop_count = 0;
  logic       done_audio = 0, end_early = 0, pause_req = 0, resume_req = 0;
  logic       change_score = 0, replay = 0;
  logic       do_new_score, enable_rand, init_audio, play_en, play_src;
  logic [1:0] play_slot;
  logic [3:0] loops_left;
  logic       paused, done, sel_err;

  int total = 0;
  int bad = 0;
  bit chk_en = 0;

  piano_play_ctrl dut (
    .clk(clk), .reset(reset), .s(s), .done_gen_score(done_gen_score),
    .do_new_score(do_new_score), .enable_rand(enable_rand),
    .play_rand(play_rand), .play_save(play_save), .save_slot(save_slot),
    .slot_valid(slot_valid), .loop_count(loop_count), .done_audio(done_audio),
    .end_early(end_early), .pause_req(pause_req), .resume_req(resume_req),
    .change_score(change_score), .replay(replay), .init_audio(init_audio),
    .play_en(play_en), .play_src(play_src), .play_slot(play_slot),
    .loops_left(loops_left), .paused(paused), .done(done), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

`ifdef PIANO_PLAY_PAUSE_EN
  localparam bit HAS_PAUSE = 1'b1;
`else
  localparam bit HAS_PAUSE = 1'b0;
`endif

  // Model: mode is one of the six named phases of playback.
  localparam int IDLE = 0, GEN = 1, READY = 2, PLAY = 3, PAUSE = 4, DONE = 5;
  int m_mode = IDLE;
  int m_loops = 0;
  int m_slot = 0;
  bit m_src = 0, m_init = 0, m_err = 0;

  function automatic bit slot_accepts(input int idx, input logic [3:0] mask);
    return (idx < 4) && (mask[idx] == 1'b1);
  endfunction

  task automatic begin_play(input bit src, input int slot);
    m_mode  = PLAY;
    m_src   = src;
    m_slot  = slot;
    m_loops = int'(loop_count);
    m_init  = 1;
  endtask

  always @(posedge clk) begin
    m_init = 0;
    m_err  = 0;
    if (reset) begin
      m_mode = IDLE; m_loops = 0; m_slot = 0; m_src = 0;
    end else if (m_mode == IDLE) begin
      if (s) m_mode = GEN;
    end else if (m_mode == GEN) begin
      if (done_gen_score) m_mode = READY;
    end else if (m_mode == PLAY || m_mode == PAUSE) begin
      if (end_early) begin
        m_mode = DONE; m_loops = 0;
      end else if (m_mode == PAUSE) begin
        if (resume_req) m_mode = PLAY;
      end else if (done_audio && m_loops > 0) begin
        m_loops = m_loops - 1; m_init = 1;
      end else if (done_audio) begin
        m_mode = DONE;
      end else if (pause_req && HAS_PAUSE) begin
        m_mode = PAUSE;
      end
    end else begin
      // READY and DONE share the selection rules; DONE adds change/replay on top.
      if (m_mode == DONE && change_score) m_mode = GEN;
      else if (m_mode == DONE && replay) begin_play(m_src, m_slot);
      else if (play_rand) begin_play(1'b0, m_slot);
      else if (play_save && slot_accepts(int'(save_slot), slot_valid)) begin_play(1'b1, int'(save_slot));
      else if (play_save) m_err = 1;
    end
  end

  always @(negedge clk) begin
    logic [13:0] exp_v, act_v;
    if (chk_en) begin
      exp_v = {m_mode == GEN, m_mode == GEN, m_mode == PLAY, m_mode == PAUSE, m_mode == DONE,
               m_init, m_err, m_src, 2'(m_slot), 4'(m_loops)};
      act_v = {do_new_score, enable_rand, play_en, paused, done,
               init_audio, sel_err, play_src, play_slot, loops_left};
      total++;
      if (act_v !== exp_v) begin
        bad++;
        $display("FAIL cycle_model t=%0t got=%b want=%b (gen,rand,en,pause,done,init,err,src,slot,loops)",
                 $time, act_v, exp_v);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  initial begin
    reset = 1;
    tick(); chk_en = 1; tick();
    chk("rst_done", done, 0);
    chk("rst_play_en", play_en, 0);
    chk("rst_loops", loops_left, 0);
    chk("rst_slot", play_slot, 0);
    reset = 0;
    tick();
    chk("idle_gen", do_new_score, 0);

    s = 1; tick(); s = 0;
    chk("gen_entry", do_new_score, 1);
    tick(); tick();
    chk("gen_hold", enable_rand, 1);
    done_gen_score = 1; tick(); done_gen_score = 0;
    chk("ready_gen", do_new_score, 0);
    chk("ready_en", play_en, 0);

    loop_count = 2; play_rand = 1; tick(); play_rand = 0;
    chk("p1_init", init_audio, 1);
    chk("p1_loops", loops_left, 2);
    chk("p1_src", play_src, 0);
    tick();
    chk("p1_init_low", init_audio, 0);
    done_audio = 1; tick(); done_audio = 0;
    chk("p2_init", init_audio, 1);
    chk("p2_loops", loops_left, 1);
    tick();
    done_audio = 1; tick(); done_audio = 0;
    chk("p3_init", init_audio, 1);
    chk("p3_loops", loops_left, 0);
    tick();
    done_audio = 1; tick(); done_audio = 0;
    chk("p4_done", done, 1);
    chk("p4_en", play_en, 0);
    chk("p4_init", init_audio, 0);

    change_score = 1; tick(); change_score = 0;
    chk("regen", do_new_score, 1);
    done_gen_score = 1; tick(); done_gen_score = 0;
    loop_count = 3; slot_valid = 4'b0111; save_slot = 3; play_save = 1; tick(); play_save = 0;
    chk("bad_slot_err", sel_err, 1);
    chk("bad_slot_en", play_en, 0);
    tick();
    chk("err_pulse_end", sel_err, 0);
    save_slot = 1; play_save = 1; tick(); play_save = 0;
    chk("save_src", play_src, 1);
    chk("save_slot", play_slot, 1);
    chk("save_init", init_audio, 1);
    chk("save_loops", loops_left, 3);

    pause_req = 1; tick(); pause_req = 0;
    chk("pause_en", play_en, HAS_PAUSE ? 0 : 1);
    chk("pause_flag", paused, HAS_PAUSE ? 1 : 0);
    repeat (9) tick();
    chk("pause_held", play_en, HAS_PAUSE ? 0 : 1);
    resume_req = 1; tick(); resume_req = 0;
    chk("resume_en", play_en, 1);
    chk("resume_init", init_audio, 0);

    end_early = 1; done_audio = 1; tick(); end_early = 0; done_audio = 0;
    chk("abort_done", done, 1);
    chk("abort_loops", loops_left, 0);

    change_score = 1; replay = 1; tick(); change_score = 0; replay = 0;
    chk("chg_over_replay", do_new_score, 1);
    done_gen_score = 1; tick(); done_gen_score = 0;
    play_rand = 1; tick(); play_rand = 0;
    end_early = 1; tick(); end_early = 0;
    loop_count = 5; replay = 1; tick(); replay = 0;
    chk("replay_init", init_audio, 1);
    chk("replay_loops", loops_left, 5);
    chk("replay_src", play_src, 0);
    chk("replay_en", play_en, 1);

    for (int i = 0; i < 4000; i++) begin
      reset          = ($urandom_range(0, 299) == 0);
      s              = ($urandom_range(0, 3) == 0);
      done_gen_score = ($urandom_range(0, 3) == 0);
      play_rand      = ($urandom_range(0, 5) == 0);
      play_save      = ($urandom_range(0, 4) == 0);
      save_slot      = 2'($urandom_range(0, 3));
      slot_valid     = 4'($urandom_range(0, 15));
      loop_count     = 4'($urandom_range(0, 3));
      done_audio     = ($urandom_range(0, 7) == 0);
      end_early      = ($urandom_range(0, 29) == 0);
      pause_req      = ($urandom_range(0, 14) == 0);
      resume_req     = ($urandom_range(0, 5) == 0);
      change_score   = ($urandom_range(0, 9) == 0);
      replay         = ($urandom_range(0, 5) == 0);
      tick();
    end

    reset = 0; s = 0; done_gen_score = 0; play_rand = 0; play_save = 0;
    done_audio = 0; end_early = 0; pause_req = 0; resume_req = 0;
    change_score = 0; replay = 0;
    tick(); tick();
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
